// File: rtl/fir_host_sequencer.sv
// Host-side sequencer for fir_filter: loads four coefficients from a shadow bank,
// then streams samples through the modwait handshake, capturing results and timeouts.
module fir_host_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        coeff_wr,
  input  logic [1:0]  coeff_idx,
  input  logic [15:0] coeff_in,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] sample_data,
  output logic [15:0] fir_coefficient,
  output logic        load_coeff,
  output logic        data_ready,
  input  logic        modwait,
  input  logic [15:0] fir_out,
  input  logic        err,
  input  logic        one_k_samples,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_err,
  output logic        coeff_loaded,
  output logic        busy,
  output logic        kilo_seen,
  output logic        timeout_err,
  output logic [15:0] sample_count
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COEF_REQ  = 3'd1,
    S_COEF_WAIT = 3'd2,
    S_SAMP_REQ  = 3'd3,
    S_SAMP_WAIT = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow [4];

  logic w_tmo;
  logic w_load_go;
  logic w_accept;
  logic w_coef_step;
  logic w_coef_done;
  logic w_samp_done;

  assign w_tmo    = (r_state != S_IDLE) && (r_cnt == CW'(TIMEOUT - 1));
  assign in_ready = (r_state == S_IDLE) && coeff_loaded && !load_start;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Timeout always wins over a handshake edge in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_start)                     w_state_nxt = S_COEF_REQ;
        else if (in_valid && coeff_loaded)  w_state_nxt = S_SAMP_REQ;
      end
      S_COEF_REQ: begin
        if (w_tmo)        w_state_nxt = S_IDLE;
        else if (modwait) w_state_nxt = S_COEF_WAIT;
      end
      S_COEF_WAIT: begin
        if (w_tmo)         w_state_nxt = S_IDLE;
        else if (!modwait) w_state_nxt = (r_idx == 2'd3) ? S_IDLE : S_COEF_REQ;
      end
      S_SAMP_REQ: begin
        if (w_tmo)        w_state_nxt = S_IDLE;
        else if (modwait) w_state_nxt = S_SAMP_WAIT;
      end
      S_SAMP_WAIT: begin
        if (w_tmo || !modwait) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load_go   = 1'b0;
    w_accept    = 1'b0;
    w_coef_step = 1'b0;
    w_coef_done = 1'b0;
    w_samp_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load_go = load_start;
        w_accept  = !load_start && in_valid && coeff_loaded;
      end
      S_COEF_WAIT: begin
        w_coef_step = !w_tmo && !modwait && (r_idx != 2'd3);
        w_coef_done = !w_tmo && !modwait && (r_idx == 2'd3);
      end
      S_SAMP_WAIT: w_samp_done = !w_tmo && !modwait;
      default: ;
    endcase
  end

  // Strobes are registered from the next state so they follow state entry exactly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      r_cnt           <= '0;
      r_idx           <= '0;
      sample_data     <= '0;
      fir_coefficient <= '0;
      load_coeff      <= 1'b0;
      data_ready      <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_err         <= 1'b0;
      coeff_loaded    <= 1'b0;
      busy            <= 1'b0;
      kilo_seen       <= 1'b0;
      timeout_err     <= 1'b0;
      sample_count    <= '0;
    end else begin
      if (coeff_wr) r_shadow[coeff_idx] <= coeff_in;

      if ((w_state_nxt != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
      else                                                 r_cnt <= r_cnt + CW'(1);

      load_coeff <= (w_state_nxt == S_COEF_REQ);
      data_ready <= (w_state_nxt == S_SAMP_REQ);
      busy       <= (w_state_nxt != S_IDLE);
      out_valid  <= w_samp_done;

      if (w_samp_done) begin
        out_data     <= fir_out;
        out_err      <= err;
        sample_count <= sample_count + 16'd1;
      end

      if (w_load_go) begin
        coeff_loaded    <= 1'b0;
        r_idx           <= 2'd0;
        fir_coefficient <= r_shadow[0];
      end else if (w_coef_step) begin
        r_idx           <= r_idx + 2'd1;
        fir_coefficient <= r_shadow[r_idx + 2'd1];
      end
      if (w_coef_done) coeff_loaded <= 1'b1;

      if (w_accept)      sample_data <= in_data;
      if (one_k_samples) kilo_seen   <= 1'b1;
      if (w_tmo)         timeout_err <= 1'b1;
    end
  end

endmodule
